// File: rtl/turn_controller.sv
// rtl/turn_controller.sv - turn sequencing for a column-drop board game
// Optional turn timer is built in when TURN_TIMEOUT_EN is defined.
module turn_controller #(
  parameter int NUM_COLS       = 7,
  parameter int START_COL      = 3,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       left,
  input  logic       right,
  input  logic       put,
  output logic       drop_req,
  output logic [2:0] drop_col,
  output logic       drop_player,
  input  logic       drop_ack,
  input  logic       drop_invalid,
  input  logic       win,
  input  logic       full,
  output logic       player,
  output logic [2:0] selected_col,
  output logic       invalid_move,
  output logic       game_over,
  output logic       timeout
);

  typedef enum logic [1:0] {S_SELECT, S_DROP, S_CHECK, S_OVER} state_e;

  localparam logic [2:0] LAST_COL = 3'(NUM_COLS - 1);
  localparam logic [2:0] HOME_COL = 3'(START_COL);

  state_e     state_q;
  logic       left_q, right_q, put_q;
  logic       player_q, drop_req_q, drop_player_q, invalid_q, game_over_q;
  logic [2:0] col_q, drop_col_q;

  logic left_e, right_e, put_e, expire;

  assign left_e  = left  & ~left_q;
  assign right_e = right & ~right_q;
  assign put_e   = put   & ~put_q;

`ifdef TURN_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;

  assign expire  = (state_q == S_SELECT) && (cnt_q == CNT_LAST);
  assign timeout = timeout_q;

  // Outside SELECT the count is held at zero so every entry starts a fresh turn.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expire & ~put_e;
      if (state_q != S_SELECT || put_e || expire) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign expire             = 1'b0;
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_SELECT;
      left_q        <= 1'b0;
      right_q       <= 1'b0;
      put_q         <= 1'b0;
      player_q      <= 1'b0;
      col_q         <= HOME_COL;
      drop_req_q    <= 1'b0;
      drop_col_q    <= 3'd0;
      drop_player_q <= 1'b0;
      invalid_q     <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      left_q  <= left;
      right_q <= right;
      put_q   <= put;
      case (state_q)
        S_SELECT: begin
          if (put_e) begin
            drop_req_q    <= 1'b1;
            drop_col_q    <= col_q;
            drop_player_q <= player_q;
            invalid_q     <= 1'b0;
            state_q       <= S_DROP;
          end else if (expire) begin
            player_q  <= ~player_q;
            col_q     <= HOME_COL;
            invalid_q <= 1'b0;
          end else if (right_e && !left_e && col_q != LAST_COL) begin
            col_q <= col_q + 3'd1;
          end else if (left_e && !right_e && col_q != 3'd0) begin
            col_q <= col_q - 3'd1;
          end
        end
        S_DROP: begin
          if (drop_ack) begin
            drop_req_q <= 1'b0;
            if (drop_invalid) begin
              invalid_q <= 1'b1;
              state_q   <= S_SELECT;
            end else begin
              invalid_q <= 1'b0;
              state_q   <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (win || full) begin
            game_over_q <= 1'b1;
            state_q     <= S_OVER;
          end else begin
            player_q <= ~player_q;
            col_q    <= HOME_COL;
            state_q  <= S_SELECT;
          end
        end
        S_OVER: begin
          state_q <= S_OVER;
        end
        default: state_q <= S_SELECT;
      endcase
    end
  end

  assign drop_req     = drop_req_q;
  assign drop_col     = drop_col_q;
  assign drop_player  = drop_player_q;
  assign player       = player_q;
  assign selected_col = col_q;
  assign invalid_move = invalid_q;
  assign game_over    = game_over_q;

endmodule

// File: tb/tb_turn_controller.sv
// tb/tb_turn_controller.sv - randomized and directed checks of turn_controller against a turn model
module tb_turn_controller;
  localparam int NC = 7;
  localparam int SC = 3;
  localparam int TO = 16;
`ifdef TURN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, left, right, put, drop_ack, drop_invalid, win, full;
  logic       drop_req, drop_player, player, invalid_move, game_over, timeout;
  logic [2:0] drop_col, selected_col;

  int n_vec  = 0;
  int n_miss = 0;
  bit check_en = 1'b0;

  turn_controller #(.NUM_COLS(NC), .START_COL(SC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .left(left), .right(right), .put(put),
    .drop_req(drop_req), .drop_col(drop_col), .drop_player(drop_player),
    .drop_ack(drop_ack), .drop_invalid(drop_invalid), .win(win), .full(full),
    .player(player), .selected_col(selected_col), .invalid_move(invalid_move),
    .game_over(game_over), .timeout(timeout)
  );

  // Turn model: what a player sees, tracked as flags and plain integers.
  int m_player, m_col, m_req, m_dcol, m_dplayer, m_inv, m_over, m_to;
  int awaiting_board, judging, turn_age;
  int pl, pr, pp;

  always @(posedge clk) begin : model
    int le, re, pe;
    m_to = 0;
    if (rst) begin
      m_player = 0; m_col = SC; m_req = 0; m_dcol = 0; m_dplayer = 0;
      m_inv = 0; m_over = 0; awaiting_board = 0; judging = 0; turn_age = 0;
      pl = 0; pr = 0; pp = 0;
    end else begin
      le = (left  && pl == 0) ? 1 : 0;
      re = (right && pr == 0) ? 1 : 0;
      pe = (put   && pp == 0) ? 1 : 0;
      pl = int'(left); pr = int'(right); pp = int'(put);
      if (m_over != 0) begin
      end else if (judging != 0) begin
        judging = 0;
        if (win || full) m_over = 1;
        else begin m_player = 1 - m_player; m_col = SC; turn_age = 0; end
      end else if (awaiting_board != 0) begin
        if (drop_ack) begin
          awaiting_board = 0; m_req = 0;
          if (drop_invalid) begin m_inv = 1; turn_age = 0; end
          else begin m_inv = 0; judging = 1; end
        end
      end else if (pe != 0) begin
        awaiting_board = 1; m_req = 1; m_dcol = m_col; m_dplayer = m_player; m_inv = 0;
      end else if (TO_EN && turn_age == TO - 1) begin
        m_to = 1; m_player = 1 - m_player; m_col = SC; m_inv = 0; turn_age = 0;
      end else begin
        if (re != 0 && le == 0 && m_col < NC - 1) m_col = m_col + 1;
        if (le != 0 && re == 0 && m_col > 0) m_col = m_col - 1;
        turn_age = turn_age + 1;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec = n_vec + 1;
    if (act != exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("drop_req",     int'(drop_req),     m_req);
      chk("drop_col",     int'(drop_col),     m_dcol);
      chk("drop_player",  int'(drop_player),  m_dplayer);
      chk("player",       int'(player),       m_player);
      chk("selected_col", int'(selected_col), m_col);
      chk("invalid_move", int'(invalid_move), m_inv);
      chk("game_over",    int'(game_over),    m_over);
      chk("timeout",      int'(timeout),      m_to);
    end
  end

  // Apply one cycle of inputs; returns at the following negedge.
  task automatic cyc(input bit r, input bit l, input bit rt, input bit p,
                     input bit a, input bit inv, input bit w, input bit f);
    rst = r; left = l; right = rt; put = p;
    drop_ack = a; drop_invalid = inv; win = w; full = f;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int rc[5] = '{4, 5, 6, 6, 6};
  int lc[8] = '{5, 4, 3, 2, 1, 0, 0, 0};

  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    check_en = 1'b1;
    chk("rst_col", int'(selected_col), 3);
    chk("rst_player", int'(player), 0);
    chk("rst_req", int'(drop_req), 0);
    chk("rst_over", int'(game_over), 0);

    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 0, 0, 0, 0, 0);
      chk("right_sat", int'(selected_col), rc[i]);
      idle();
    end
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 0, 0);
    chk("col_after_reject", int'(selected_col), 6);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0, 0, 0, 0, 0, 0);
      chk("left_sat", int'(selected_col), lc[i]);
      idle();
    end

    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) begin cyc(0, 0, 1, 0, 0, 0, 0, 0); idle(); end
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    chk("put_req", int'(drop_req), 1);
    chk("put_col", int'(drop_col), 5);
    chk("put_player", int'(drop_player), 0);
    idle(); idle();
    chk("req_hold", int'(drop_req), 1);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    chk("ack_req", int'(drop_req), 0);
    idle();
    chk("turn_player", int'(player), 1);
    chk("turn_col", int'(selected_col), 3);

    cyc(0, 0, 1, 0, 0, 0, 0, 0); idle();
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    chk("b_col", int'(drop_col), 4);
    chk("b_player", int'(drop_player), 1);
    cyc(0, 0, 0, 0, 1, 1, 0, 0);
    chk("rej_inv", int'(invalid_move), 1);
    chk("rej_req", int'(drop_req), 0);
    idle();
    chk("rej_player", int'(player), 1);
    chk("rej_col", int'(selected_col), 4);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    chk("inv_clear", int'(invalid_move), 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    chk("win_over", int'(game_over), 1);
    chk("win_player", int'(player), 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, i == 1, i == 2, i == 0, 0, 0, 0, 0);
      idle();
      chk("over_noreq", int'(drop_req), 0);
    end

    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_drop_req", int'(drop_req), 0);
    chk("rst_drop_player", int'(player), 0);
    chk("rst_drop_col", int'(selected_col), 3);
    cyc(0, 1, 1, 0, 0, 0, 0, 0);
    chk("lr_cancel", int'(selected_col), 3);

`ifdef TURN_TIMEOUT_EN
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (15) idle();
    chk("to_early", int'(timeout), 0);
    idle();
    chk("to_pulse", int'(timeout), 1);
    chk("to_player", int'(player), 1);
    repeat (15) idle();
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    chk("to_put_req", int'(drop_req), 1);
    chk("to_put_none", int'(timeout), 0);
`endif

    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 149) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
    end

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/turn_controller.md
TURN_CONTROLLER -- requirements
Module: turn_controller

Interface
REQ-001 SHALL have parameters: NUM_COLS, 7, number of board columns; START_COL, 3, cursor position at reset and at each new turn; TIMEOUT_CYCLES, 50_000_000, turn length in clocks.
REQ-002 SHALL have ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- left  in  1  button, pre-synchronized level
- right  in  1  button, pre-synchronized level
- put  in  1  button, pre-synchronized level
- drop_req  out  1  drop request to board datapath
- drop_col  out  3  column of requested drop
- drop_player  out  1  owner of requested drop
- drop_ack  in  1  board accepted or rejected the drop, 1-cycle pulse
- drop_invalid  in  1  rejection flag, qualified by drop_ack
- win  in  1  board reports four-in-a-row
- full  in  1  board reports all cells occupied
- player  out  1  active player (0 = A, 1 = B)
- selected_col  out  3  cursor column
- invalid_move  out  1  last drop was rejected
- game_over  out  1  game ended
- timeout  out  1  turn expired, 1-cycle pulse

Function
REQ-003 SHALL register left, right and put each cycle; a rising edge is the input at 1 while its previous sample is 0.
REQ-004 SHALL implement the states SELECT, DROP, CHECK and OVER.
REQ-005 In SELECT, SHALL give edge priority put > (right, left); simultaneous right and left edges SHALL cancel; edges in any other state SHALL be discarded.
REQ-006 In SELECT, a right edge SHALL increment selected_col, saturating at NUM_COLS-1; a left edge SHALL decrement it, saturating at 0.
REQ-007 A put edge in SELECT at cycle N SHALL latch drop_col=selected_col and drop_player=player, and SHALL assert drop_req at N+1 (state DROP).
REQ-008 drop_req, drop_col and drop_player SHALL hold stable until drop_ack; drop_ack outside DROP SHALL be ignored.
REQ-009 drop_ack at cycle M with drop_invalid=1 SHALL deassert drop_req at M+1, set invalid_move, and return to SELECT with the same player and cursor.
REQ-010 drop_ack at cycle M with drop_invalid=0 SHALL deassert drop_req at M+1 and enter CHECK; invalid_move SHALL clear at M+1.
REQ-011 invalid_move SHALL also clear on the next accepted put edge.
REQ-012 In CHECK, SHALL sample win and full: if either is 1, enter OVER with player unchanged; otherwise toggle player, set selected_col=START_COL and enter SELECT.
REQ-013 In OVER, game_over SHALL be 1, all outputs SHALL hold, and only rst SHALL exit.

Reset
REQ-014 rst SHALL force the following outputs at the next clk edge: state SELECT, player 0, selected_col START_COL, drop_req 0, drop_col 0, drop_player 0, invalid_move 0, game_over 0, timeout 0.
REQ-015 rst SHALL clear the edge registers and the turn counter to 0; rst during DROP SHALL drop drop_req at the next edge.

Configuration
REQ-016 With macro TURN_TIMEOUT_EN defined, SHALL count clocks spent in SELECT, restarting at 0 on every entry to SELECT.
REQ-017 With TURN_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES-1 without a put edge SHALL:
- pulse timeout for 1 cycle;
- toggle player;
- set selected_col=START_COL;
- clear invalid_move;
- restart the count.
A put edge in the expiry cycle SHALL take precedence over the timeout.
REQ-018 Without TURN_TIMEOUT_EN, SHALL have no counter and timeout SHALL be tied to 0.

Verification
REQ-019 SHALL cover the following directed scenarios:
- rst, then 5 right edges -> selected_col 3,4,5,6,6,6 (saturates); then 8 left edges -> saturates at 0.
- put edge at cycle 10 -> drop_req=1 at cycle 11 with drop_col=selected_col and drop_player=0; ack (valid) at cycle 14 -> drop_req=0 at 15; win=full=0 -> player=1 and selected_col=3 at cycle 16.
- ack with drop_invalid=1 -> invalid_move=1, player unchanged, back in SELECT; next put edge clears invalid_move.
- win=1 in CHECK -> game_over=1 and player frozen; further put, left and right edges produce no drop_req.
- rst asserted while drop_req=1 -> drop_req=0, player=0, selected_col=3 next cycle; simultaneous left and right edges -> selected_col unchanged.
- TURN_TIMEOUT_EN with TIMEOUT_CYCLES=16 and no buttons -> timeout pulses 16 cycles after SELECT entry and player toggles; put edge in the expiry cycle -> drop_req asserted and no timeout pulse.
